// File: rtl/add_subt_seq.sv
// add_subt_seq: 16-bit add/subtract computed one nibble per cycle through a
// single 4-bit ripple slice; IDLE -> RUN (4 nibbles) -> DONE (one-cycle done).
module add_subt_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        Op,
    input  logic [15:0] Input_1,
    input  logic [15:0] Input_2,
    output logic [15:0] Res,
    output logic        Out,
    output logic        Ovf,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        carry_q, carry_d;
    logic        op_q, op_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [15:0] res_q, res_d;
    logic        out_q, out_d, ovf_q, ovf_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [3:0]  an, bn, sn;
    logic [4:0]  c;

    // Nibble slice: b is inverted for subtract; the +1 comes from the carry seed.
    always_comb begin
        an = a_q[4*cnt_q +: 4];
        bn = b_q[4*cnt_q +: 4] ^ {4{op_q}};
        c = '0;
        c[0] = carry_q;
        sn = '0;
        for (int i = 0; i < 4; i++) begin
            sn[i] = an[i] ^ bn[i] ^ c[i];
            c[i+1] = (an[i] & bn[i]) | (an[i] & c[i]) | (bn[i] & c[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        carry_d = carry_q;
        op_d = op_q;
        a_d = a_q;
        b_d = b_q;
        res_d = res_q;
        out_d = out_q;
        ovf_d = ovf_q;
        busy_d = busy_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                a_d = Input_1;
                b_d = Input_2;
                op_d = Op;
                cnt_d = 2'd0;
                carry_d = Op;
                busy_d = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                res_d[4*cnt_q +: 4] = sn;
                carry_d = c[4];
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    out_d = c[4];
                    ovf_d = c[3] ^ c[4];
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            carry_q <= 1'b0;
            op_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            res_q <= '0;
            out_q <= 1'b0;
            ovf_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            carry_q <= carry_d;
            op_q <= op_d;
            a_q <= a_d;
            b_q <= b_d;
            res_q <= res_d;
            out_q <= out_d;
            ovf_q <= ovf_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign Res = res_q;
    assign Out = out_q;
    assign Ovf = ovf_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule
